// File: rtl/simon_pkg.sv
// Shared definitions for the colour-button front end: colour codes, press FSM states, defaults.
package simon_pkg;

    localparam logic [1:0] COLOUR_0 = 2'd0;
    localparam logic [1:0] COLOUR_1 = 2'd1;
    localparam logic [1:0] COLOUR_2 = 2'd2;
    localparam logic [1:0] COLOUR_3 = 2'd3;

    // 5 ms at 10 MHz
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50000;

    typedef enum logic [1:0] {
        PS_IDLE    = 2'd0,
        PS_PRESSED = 2'd1,
        PS_LOCKOUT = 2'd2
    } press_state_e;

    function automatic logic is_one_hot(logic [3:0] b);
        return (b != 4'b0000) && ((b & (b - 4'd1)) == 4'b0000);
    endfunction

    function automatic logic [1:0] colour_encode(logic [3:0] b);
        logic [1:0] c;
        case (b)
            4'b0010: c = COLOUR_1;
            4'b0100: c = COLOUR_2;
            4'b1000: c = COLOUR_3;
            default: c = COLOUR_0;
        endcase
        return c;
    endfunction

    function automatic logic [3:0] colour_decode(logic [1:0] c);
        return 4'b0001 << c;
    endfunction

endpackage

// File: rtl/btn_debounce_bit.sv
// Two-flop synchroniser plus consecutive-sample debounce counter for one button.
// BTN_DEBOUNCE_BYPASS_EN drops the counter and passes the synchronised level straight out.
module btn_debounce_bit
    import simon_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic stable_o
);

    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef BTN_DEBOUNCE_BYPASS_EN
    assign stable_o = sync2_q;
`else
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stable_q;
    logic             stable_d;

    // Counter measures how long sync has disagreed with the accepted level.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Debounces the four colour buttons and emits one clean event per legitimate press.
// Define BTN_DEBOUNCE_BYPASS_EN to skip debouncing (stable level = synchronised level).
module button_conditioner
    import simon_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    input  logic       en,
    output logic [3:0] btn_stable,
    output logic       colour_valid,
    output logic [1:0] colour_val,
    output logic       multi_err
);

    for (genvar i = 0; i < 4; i++) begin : g_bit
        btn_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk_i   (clk),
            .rst_i   (rst),
            .raw_i   (btn_raw[i]),
            .stable_o(btn_stable[i])
        );
    end

    press_state_e state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= PS_IDLE;
            colour_valid <= 1'b0;
            colour_val   <= COLOUR_0;
            multi_err    <= 1'b0;
        end else begin
            colour_valid <= 1'b0;
            multi_err    <= 1'b0;
            unique case (state_q)
                PS_IDLE: begin
                    if (btn_stable != 4'b0000) begin
                        if (!is_one_hot(btn_stable)) begin
                            multi_err <= 1'b1;
                            state_q   <= PS_LOCKOUT;
                        end else if (en) begin
                            colour_valid <= 1'b1;
                            colour_val   <= colour_encode(btn_stable);
                            state_q      <= PS_PRESSED;
                        end else begin
                            state_q <= PS_LOCKOUT;
                        end
                    end
                end
                PS_PRESSED: begin
                    // colour_val still names the held button, so anything else is extra.
                    if (btn_stable == 4'b0000) begin
                        state_q <= PS_IDLE;
                    end else if ((btn_stable & ~colour_decode(colour_val)) != 4'b0000) begin
                        multi_err <= 1'b1;
                        state_q   <= PS_LOCKOUT;
                    end
                end
                PS_LOCKOUT: begin
                    if (btn_stable == 4'b0000) begin
                        state_q <= PS_IDLE;
                    end
                end
                default: state_q <= PS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: phase table, directed corners, random vs model.
module tb_button_conditioner;

    localparam int D = 8;
`ifdef BTN_DEBOUNCE_BYPASS_EN
    localparam int STAB_LAT = 2;
`else
    localparam int STAB_LAT = D + 2;
`endif
    localparam int LAT = STAB_LAT + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_raw = 4'b0000;
    logic       en = 1'b0;
    logic [3:0] btn_stable;
    logic       colour_valid;
    logic [1:0] colour_val;
    logic       multi_err;

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .en          (en),
        .btn_stable  (btn_stable),
        .colour_valid(colour_valid),
        .colour_val  (colour_val),
        .multi_err   (multi_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: raw samples per edge, newest first; mode 0 idle, 1 pressed, 2 lockout.
    logic [3:0] hist[$];
    logic [3:0] m_stable;
    int         m_mode;
    logic       m_valid;
    logic       m_multi;
    logic [1:0] m_colour;

    task automatic model_reset();
        hist = {};
        for (int k = 0; k < D + 4; k++) hist.push_front(4'b0000);
        m_stable = 4'b0000;
        m_mode   = 0;
        m_valid  = 1'b0;
        m_multi  = 1'b0;
        m_colour = 2'd0;
    endtask

    task automatic model_step();
        logic [3:0] prev;
        logic       flip;
        int         idx;
        if (rst) begin
            model_reset();
            return;
        end
        hist.push_front(btn_raw);
        void'(hist.pop_back());
        prev = m_stable;
`ifdef BTN_DEBOUNCE_BYPASS_EN
        m_stable = hist[1];
`else
        // A level is accepted once the synchronised input has shown it for D edges in a row.
        for (int b = 0; b < 4; b++) begin
            flip = 1'b1;
            for (int k = 2; k <= D + 1; k++) if (hist[k][b] == prev[b]) flip = 1'b0;
            if (flip) m_stable[b] = ~prev[b];
        end
`endif
        m_valid = 1'b0;
        m_multi = 1'b0;
        idx = 0;
        for (int b = 0; b < 4; b++) if (prev[b]) idx = b;
        if (m_mode == 0) begin
            if ($countones(prev) > 1) begin
                m_multi = 1'b1;
                m_mode  = 2;
            end else if ($countones(prev) == 1) begin
                if (en) begin
                    m_valid  = 1'b1;
                    m_colour = 2'(idx);
                    m_mode   = 1;
                end else begin
                    m_mode = 2;
                end
            end
        end else if (m_mode == 1) begin
            if (prev == 4'b0000) m_mode = 0;
            else if ($countones(prev) > 1 || prev[m_colour] == 1'b0) begin
                m_multi = 1'b1;
                m_mode  = 2;
            end
        end else begin
            if (prev == 4'b0000) m_mode = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        chk("model_btn_stable", 32'(btn_stable), 32'(m_stable));
        chk("model_colour_valid", 32'(colour_valid), 32'(m_valid));
        chk("model_multi_err", 32'(multi_err), 32'(m_multi));
        chk("model_colour_val", 32'(colour_val), 32'(m_colour));
    endtask

    // Ticks until colour_valid is seen; returns edge count, or -1 if the budget expires.
    task automatic wait_valid(output int edges);
        edges = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (colour_valid) begin
                edges = k;
                break;
            end
        end
    endtask

    typedef struct {
        logic [3:0] btn;
        logic       en;
        int         cycles;
        int         n_valid;
        int         n_multi;
        logic [1:0] colour;
        logic [3:0] stable;
    } vec_t;

    vec_t vecs[16];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        int nm;
        int edges;
        int kind;
        int hold;

        vecs[0]  = '{4'b0000, 1'b1, 20, 0, 0, 2'd0, 4'b0000};
        vecs[1]  = '{4'b0100, 1'b1, 20, 1, 0, 2'd2, 4'b0100};
        vecs[2]  = '{4'b0000, 1'b1, 20, 0, 0, 2'd2, 4'b0000};
        vecs[3]  = '{4'b1001, 1'b1, 20, 0, 1, 2'd2, 4'b1001};
        vecs[4]  = '{4'b0000, 1'b1, 20, 0, 0, 2'd2, 4'b0000};
        vecs[5]  = '{4'b0010, 1'b1, 20, 1, 0, 2'd1, 4'b0010};
        vecs[6]  = '{4'b0000, 1'b1, 20, 0, 0, 2'd1, 4'b0000};
        vecs[7]  = '{4'b1000, 1'b0, 20, 0, 0, 2'd1, 4'b1000};
        vecs[8]  = '{4'b1000, 1'b1, 20, 0, 0, 2'd1, 4'b1000};
        vecs[9]  = '{4'b0000, 1'b1, 20, 0, 0, 2'd1, 4'b0000};
        vecs[10] = '{4'b1000, 1'b1, 20, 1, 0, 2'd3, 4'b1000};
        vecs[11] = '{4'b1010, 1'b1, 20, 0, 1, 2'd3, 4'b1010};
        vecs[12] = '{4'b0000, 1'b1, 20, 0, 0, 2'd3, 4'b0000};
        vecs[13] = '{4'b0001, 1'b1, 20, 1, 0, 2'd0, 4'b0001};
        vecs[14] = '{4'b0001, 1'b0, 20, 0, 0, 2'd0, 4'b0001};
        vecs[15] = '{4'b0000, 1'b1, 20, 0, 0, 2'd0, 4'b0000};

        model_reset();
        #1;
        chk("reset_btn_stable", 32'(btn_stable), 0);
        chk("reset_colour_valid", 32'(colour_valid), 0);
        chk("reset_colour_val", 32'(colour_val), 0);
        chk("reset_multi_err", 32'(multi_err), 0);
        tick();
        tick();
        rst = 1'b0;

        // Phase table
        for (int v = 0; v < 16; v++) begin
            btn_raw = vecs[v].btn;
            en      = vecs[v].en;
            nv = 0;
            nm = 0;
            for (int c = 0; c < vecs[v].cycles; c++) begin
                tick();
                nv += int'(colour_valid);
                nm += int'(multi_err);
            end
            chk($sformatf("vec%0d_valid_count", v), 32'(nv), 32'(vecs[v].n_valid));
            chk($sformatf("vec%0d_multi_count", v), 32'(nm), 32'(vecs[v].n_multi));
            chk($sformatf("vec%0d_colour_val", v), 32'(colour_val), 32'(vecs[v].colour));
            chk($sformatf("vec%0d_btn_stable", v), 32'(btn_stable), 32'(vecs[v].stable));
        end

        // Single press latency and pulse width
        en = 1'b1;
        btn_raw = 4'b0100;
        wait_valid(edges);
        chk("press_latency", 32'(edges), 32'(LAT));
        chk("press_colour", 32'(colour_val), 2);
        chk("press_btn_stable", 32'(btn_stable), 32'(4'b0100));
        tick();
        chk("press_pulse_width", 32'(colour_valid), 0);
        chk("press_colour_held", 32'(colour_val), 2);
        btn_raw = 4'b0000;
        repeat (20) tick();

`ifndef BTN_DEBOUNCE_BYPASS_EN
        // Bounce on bit 0, then a clean hold
        nv = 0;
        nm = 0;
        for (int s = 0; s < 10; s++) begin
            btn_raw = (s % 2 == 0) ? 4'b0001 : 4'b0000;
            repeat (3) begin
                tick();
                nv += int'(colour_valid);
                nm += int'(multi_err);
            end
        end
        chk("bounce_no_valid", 32'(nv), 0);
        chk("bounce_no_multi", 32'(nm), 0);
        btn_raw = 4'b0001;
        wait_valid(edges);
        chk("bounce_latency", 32'(edges), 32'(LAT));
        chk("bounce_colour", 32'(colour_val), 0);
`else
        btn_raw = 4'b0001;
        wait_valid(edges);
        chk("hold_latency", 32'(edges), 32'(LAT));
        chk("hold_colour", 32'(colour_val), 0);
`endif

        // Reset while PRESSED with bit 0 still held
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("midrst_btn_stable", 32'(btn_stable), 0);
        chk("midrst_colour_valid", 32'(colour_valid), 0);
        chk("midrst_colour_val", 32'(colour_val), 0);
        chk("midrst_multi_err", 32'(multi_err), 0);
        tick();
        tick();
        rst = 1'b0;
        edges = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (btn_stable == 4'b0001) begin
                edges = k;
                break;
            end
        end
        chk("rst_restable_latency", 32'(edges), 32'(STAB_LAT));
        tick();
        chk("rst_refire_valid", 32'(colour_valid), 1);
        chk("rst_refire_colour", 32'(colour_val), 0);
        btn_raw = 4'b0000;
        repeat (20) tick();

        // Randomised traffic against the model
        for (int seg = 0; seg < 300; seg++) begin
            kind = int'($urandom_range(0, 3));
            case (kind)
                0: btn_raw = 4'b0000;
                1: btn_raw = 4'b0001 << $urandom_range(0, 3);
                2: btn_raw = 4'($urandom_range(0, 15));
                default: btn_raw = btn_raw ^ (4'b0001 << $urandom_range(0, 3));
            endcase
            en = ($urandom_range(0, 3) != 0);
            hold = int'($urandom_range(1, 14));
            repeat (hold) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end stage for the four colour buttons. It synchronises and debounces the raw button pins and qualifies presses. It then emits exactly one single-cycle colour event per legitimate press, to be consumed directly by the wait stage's `colour_in` / `colour_val` inputs. Raw pin glitches, bounce, simultaneous multi-button presses and presses held across enable are all filtered here, so downstream stages see clean events only.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 50000, number of consecutive stable synchronised samples required to accept a level change (5 ms at 10 MHz). Legal range is 2..2^CNT_W-1.
- `CNT_W`, default 16, width of each per-button debounce counter.

Ports:
- `clk` in 1: system clock; all state is rising-edge.
- `rst` in 1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `btn_raw` in 4: raw active-high buttons, asynchronous to `clk`. Bit i is colour i.
- `en` in 1: event enable, high while the wait stage is accepting input.
- `btn_stable` out 4: debounced button levels.
- `colour_valid` out 1: one-cycle pulse per accepted press.
- `colour_val` out 2: encoded colour of the last accepted press. Held between pulses.
- `multi_err` out 1: one-cycle pulse when more than one button is detected.

## Operation
- **Synchroniser:** each `btn_raw[i]` passes through two flops to give `sync[i]`.
- **Debounce, per bit:**
  - If `sync` equals `stable`, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter equals `DEBOUNCE_CYCLES-1` while still mismatched, `stable` takes `sync` and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `stable`.
- **Press FSM** (evaluated on `btn_stable`):
  - **IDLE** (no button held):
    - Stable exactly one-hot and `en`=1: pulse `colour_valid`, load `colour_val` with the index of the set bit, go to PRESSED.
    - Stable one-hot and `en`=0: go to LOCKOUT with no event.
    - Two or more bits set: pulse `multi_err`, go to LOCKOUT.
  - **PRESSED:**
    - Stable = 0: go to IDLE.
    - Any additional bit set: pulse `multi_err`, go to LOCKOUT. No second event is emitted.
  - **LOCKOUT:** stay until stable = 0, then go to IDLE.
- **Encoding:** bit0 maps to 2'd0, bit1 to 2'd1, bit2 to 2'd2, bit3 to 2'd3.
- **Reset values:** all outputs 0; FSM in IDLE; counters and sync flops 0.
- **Reset mid-operation:** state is lost immediately. A button still held at reset release is re-debounced from 0 and fires normally if `en`=1 when it becomes stable.

## Timing
- `btn_raw` rising to `btn_stable` rising takes 2 + `DEBOUNCE_CYCLES` clock edges, with the input held constant throughout.
- `colour_valid` and `multi_err` are registered, asserted 1 cycle after `btn_stable` satisfies the transition condition. Each is high for exactly 1 cycle.
- Total press-to-event latency is 3 + `DEBOUNCE_CYCLES` cycles.
- `colour_val` updates in the same cycle `colour_valid` rises and is stable until the next event.
- Two bits that become stable on the same edge count as a multi-press: the response is `multi_err` with no `colour_valid`.
- `en` is sampled only in IDLE. Dropping `en` while in PRESSED has no effect.

## Configuration
- Macro: `BTN_DEBOUNCE_BYPASS_EN`.
- **Defined:** debounce counters are not built. `btn_stable` = `sync`, so press-to-event latency is 3 cycles. Used for cocotb runs and gate-level sims. `DEBOUNCE_CYCLES` and `CNT_W` are ignored.
- **Undefined (default):** full debounce as specified above.

## Structure
- The shared package `simon_pkg` holds:
  - colour code constants `COLOUR_0..COLOUR_3` (2-bit);
  - the press FSM state encoding `PS_IDLE`, `PS_PRESSED`, `PS_LOCKOUT`;
  - the default `DEBOUNCE_CYCLES`.
- Sub-module `btn_debounce_bit` (synchroniser plus counter for one bit) is instantiated 4 times. The FSM and encoder live in the top level.

## Test plan
All directed tests use `DEBOUNCE_CYCLES`=8 unless noted.
- **Single press:** `en`=1, `btn_raw`=4'b0100 held 20 cycles → `colour_valid` high for exactly 1 cycle at edge 11 after assertion; `colour_val`=2; `btn_stable`=4'b0100.
- **Bounce:** toggle `btn_raw[0]` every 3 cycles for 30 cycles, then hold high → no event during toggling; exactly one event with `colour_val`=0 at 11 cycles after the final hold.
- **Simultaneous press:** `btn_raw`=4'b1001 applied in the same cycle → `multi_err` pulse; no `colour_valid`. After release, press 4'b0010 → event with `colour_val`=1.
- **Disabled press:** `en`=0, hold 4'b1000, then raise `en` while held → no event. Release, re-press → event with `colour_val`=3.
- **Reset mid-hold:** assert `rst` while in PRESSED with 4'b0001 still held → outputs 0 immediately. After `rst` falls: `btn_stable`=1 after 10 cycles and one event fires.
- **Bypass build** (`BTN_DEBOUNCE_BYPASS_EN` defined): press 4'b0010 → `colour_valid` 3 cycles later with `colour_val`=1.
